as5600_i2c_target: RTL and testbench

//  I2C target (slave) emulating an AS5600 magnetic encoder; the responding end of the angle-read transaction issued by the FOC sensor path.

---
 rtl/as5600_pkg.sv | 31 +++
 rtl/as5600_i2c_target_line_filter.sv | 52 +++++
 rtl/as5600_i2c_target.sv | 242 ++++++++++++++++++++++++
 tb/tb_as5600_i2c_target.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/as5600_pkg.sv
// AS5600 target emulation: shared constants, register map and FSM state type.
package as5600_pkg;

   // Default 7-bit bus address of the AS5600
   localparam logic [6:0] I2C_ADDR_DEFAULT = 7'h36;

   // Register map
   localparam logic [7:0] REG_ZPOS_H = 8'h01;
   localparam logic [7:0] REG_ZPOS_L = 8'h02;
   localparam logic [7:0] REG_STATUS = 8'h0B;
   localparam logic [7:0] REG_RAW_H  = 8'h0C;
   localparam logic [7:0] REG_RAW_L  = 8'h0D;
   localparam logic [7:0] REG_ANG_H  = 8'h0E;
   localparam logic [7:0] REG_ANG_L  = 8'h0F;

   // STATUS reads back with MD (magnet detected) set
   localparam logic [7:0] STATUS_VAL = 8'h20;

   typedef enum logic [3:0] {
      StIdle,
      StAddr,
      StAddrAck,
      StPtr,
      StPtrAck,
      StWdata,
      StWdataAck,
      StRdata,
      StRdAck
   } i2c_state_e;

endpackage

// File: rtl/as5600_i2c_target_line_filter.sv
// i2c_line_filter: 2-FF synchronizer, FILT_LEN-sample glitch filter and
// registered rise/fall strobes that coincide with the filtered level change.
module i2c_line_filter #(
   parameter int unsigned FILT_LEN = 3
) (
   input  logic clk,
   input  logic rstn,
   input  logic line,
   output logic level,
   output logic rise,
   output logic fall
);

   localparam int unsigned CW = $clog2(FILT_LEN + 1);

   logic [1:0]    sync_q;
   logic [CW-1:0] cnt_q;
   logic [1:0]    prime_q;

   // Synchronize, then accept a new level only after FILT_LEN equal samples.
   // For the first cycles after reset the level follows the synchronizer
   // silently so a line already low at reset release is not seen as an edge.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync_q  <= 2'b11;
         cnt_q   <= '0;
         prime_q <= '0;
         level   <= 1'b1;
         rise    <= 1'b0;
         fall    <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], line};
         rise   <= 1'b0;
         fall   <= 1'b0;
         if (prime_q != 2'd3) begin
            prime_q <= prime_q + 2'd1;
            level   <= sync_q[1];
            cnt_q   <= '0;
         end else if (sync_q[1] == level) begin
            cnt_q <= '0;
         end else if (cnt_q == CW'(FILT_LEN - 1)) begin
            level <= sync_q[1];
            rise  <= sync_q[1];
            fall  <= ~sync_q[1];
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_q + CW'(1);
         end
      end
   end

endmodule

// File: rtl/as5600_i2c_target.sv
// as5600_i2c_target: I2C target emulating the AS5600 angle registers.
// Optional feature macro AS5600_TGT_WRITE_EN: writable ZPOS offset at
// 0x01/0x02 and ANGLE = snapshot - ZPOS; without it data writes are NACKed.
module as5600_i2c_target
   import as5600_pkg::*;
#(
   parameter logic [6:0]  I2C_ADDR = I2C_ADDR_DEFAULT,
   parameter int unsigned FILT_LEN = 3
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        scl,
   inout  wire         sda,
   input  logic [11:0] i_phi,
   output logic        o_busy,
   output logic        o_snap
);

`ifdef AS5600_TGT_WRITE_EN
   localparam bit WriteEn = 1'b1;
`else
   localparam bit WriteEn = 1'b0;
`endif

   logic scl_lvl, scl_rise, scl_fall;
   logic sda_lvl, sda_rise, sda_fall;

   i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
      .clk   (clk),
      .rstn  (rstn),
      .line  (scl),
      .level (scl_lvl),
      .rise  (scl_rise),
      .fall  (scl_fall)
   );

   i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
      .clk   (clk),
      .rstn  (rstn),
      .line  (sda),
      .level (sda_lvl),
      .rise  (sda_rise),
      .fall  (sda_fall)
   );

   i2c_state_e  state_q;
   logic [3:0]  bit_cnt_q;
   logic [6:0]  rx_q;
   logic [7:0]  tx_q;
   logic [7:0]  ptr_q;
   logic [11:0] snap_q;
   logic        rw_q;
   logic        ack_half_q;
   logic        mack_q;
   logic        wr_ack_q;
   logic        sda_oe_q;
   logic [7:0]  rx_byte;
   logic [7:0]  rd_data;
   logic [11:0] angle;
   logic        start_det, stop_det;

`ifdef AS5600_TGT_WRITE_EN
   logic [11:0] zpos_q;
`endif

   assign start_det = sda_fall & scl_lvl;
   assign stop_det  = sda_rise & scl_lvl;
   assign rx_byte   = {rx_q, sda_lvl};
   assign sda       = sda_oe_q ? 1'b0 : 1'bz;

   // Register read mux, always from the per-transaction snapshot
   always_comb begin
      rd_data = 8'h00;
`ifdef AS5600_TGT_WRITE_EN
      angle = snap_q - zpos_q;
`else
      angle = snap_q;
`endif
      case (ptr_q)
`ifdef AS5600_TGT_WRITE_EN
         REG_ZPOS_H: rd_data = {4'h0, zpos_q[11:8]};
         REG_ZPOS_L: rd_data = zpos_q[7:0];
`endif
         REG_STATUS: rd_data = STATUS_VAL;
         REG_RAW_H:  rd_data = {4'h0, snap_q[11:8]};
         REG_RAW_L:  rd_data = snap_q[7:0];
         REG_ANG_H:  rd_data = {4'h0, angle[11:8]};
         REG_ANG_L:  rd_data = angle[7:0];
         default:    rd_data = 8'h00;
      endcase
   end

   // Protocol FSM; ACK states use ack_half_q to tell the first SCL fall
   // (start driving) from the second (end of the 9th clock).
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= StIdle;
         bit_cnt_q  <= '0;
         rx_q       <= '0;
         tx_q       <= '0;
         ptr_q      <= 8'h00;
         snap_q     <= '0;
         rw_q       <= 1'b0;
         ack_half_q <= 1'b0;
         mack_q     <= 1'b0;
         wr_ack_q   <= 1'b0;
         sda_oe_q   <= 1'b0;
         o_busy     <= 1'b0;
         o_snap     <= 1'b0;
`ifdef AS5600_TGT_WRITE_EN
         zpos_q     <= '0;
`endif
      end else begin
         o_snap <= 1'b0;
         if (start_det) begin
            state_q    <= StAddr;
            bit_cnt_q  <= '0;
            ack_half_q <= 1'b0;
            sda_oe_q   <= 1'b0;
         end else if (stop_det) begin
            state_q  <= StIdle;
            sda_oe_q <= 1'b0;
            o_busy   <= 1'b0;
         end else begin
            unique case (state_q)
               StIdle: ;
               StAddr: if (scl_rise) begin
                  rx_q      <= rx_byte[6:0];
                  bit_cnt_q <= bit_cnt_q + 4'd1;
                  if (bit_cnt_q == 4'd7) begin
                     if (rx_byte[7:1] == I2C_ADDR) begin
                        state_q <= StAddrAck;
                        rw_q    <= rx_byte[0];
                        o_busy  <= 1'b1;
                     end else begin
                        state_q <= StIdle;
                        o_busy  <= 1'b0;
                     end
                  end
               end
               StAddrAck: if (scl_rise && rw_q) begin
                  snap_q <= i_phi;
                  o_snap <= 1'b1;
               end else if (scl_fall) begin
                  if (!ack_half_q) begin
                     ack_half_q <= 1'b1;
                     sda_oe_q   <= 1'b1;
                  end else begin
                     ack_half_q <= 1'b0;
                     bit_cnt_q  <= '0;
                     if (rw_q) begin
                        state_q  <= StRdata;
                        sda_oe_q <= ~rd_data[7];
                        tx_q     <= {rd_data[6:0], 1'b0};
                     end else begin
                        state_q  <= StPtr;
                        sda_oe_q <= 1'b0;
                     end
                  end
               end
               StPtr: if (scl_rise) begin
                  rx_q      <= rx_byte[6:0];
                  bit_cnt_q <= bit_cnt_q + 4'd1;
                  if (bit_cnt_q == 4'd7) begin
                     ptr_q   <= rx_byte;
                     state_q <= StPtrAck;
                  end
               end
               StPtrAck: if (scl_fall) begin
                  if (!ack_half_q) begin
                     ack_half_q <= 1'b1;
                     sda_oe_q   <= 1'b1;
                  end else begin
                     ack_half_q <= 1'b0;
                     sda_oe_q   <= 1'b0;
                     bit_cnt_q  <= '0;
                     state_q    <= StWdata;
                  end
               end
               StWdata: if (scl_rise) begin
                  rx_q      <= rx_byte[6:0];
                  bit_cnt_q <= bit_cnt_q + 4'd1;
                  if (bit_cnt_q == 4'd7) begin
                     state_q  <= StWdataAck;
                     wr_ack_q <= WriteEn;
`ifdef AS5600_TGT_WRITE_EN
                     if (ptr_q == REG_ZPOS_H) zpos_q[11:8] <= rx_byte[3:0];
                     if (ptr_q == REG_ZPOS_L) zpos_q[7:0]  <= rx_byte;
                     ptr_q <= ptr_q + 8'd1;
`endif
                  end
               end
               StWdataAck: if (scl_fall) begin
                  if (!ack_half_q) begin
                     ack_half_q <= 1'b1;
                     sda_oe_q   <= wr_ack_q;
                  end else begin
                     ack_half_q <= 1'b0;
                     sda_oe_q   <= 1'b0;
                     bit_cnt_q  <= '0;
                     if (wr_ack_q) begin
                        state_q <= StWdata;
                     end else begin
                        state_q <= StIdle;
                        o_busy  <= 1'b0;
                     end
                  end
               end
               StRdata: if (scl_rise) begin
                  bit_cnt_q <= bit_cnt_q + 4'd1;
               end else if (scl_fall) begin
                  if (bit_cnt_q == 4'd8) begin
                     sda_oe_q <= 1'b0;
                     state_q  <= StRdAck;
                  end else begin
                     sda_oe_q <= ~tx_q[7];
                     tx_q     <= {tx_q[6:0], 1'b0};
                  end
               end
               // Pointer advances after every byte read, ACKed or not
               StRdAck: if (scl_rise) begin
                  mack_q <= ~sda_lvl;
                  ptr_q  <= ptr_q + 8'd1;
               end else if (scl_fall) begin
                  bit_cnt_q <= '0;
                  if (mack_q) begin
                     state_q  <= StRdata;
                     sda_oe_q <= ~rd_data[7];
                     tx_q     <= {rd_data[6:0], 1'b0};
                  end else begin
                     state_q  <= StIdle;
                     sda_oe_q <= 1'b0;
                     o_busy   <= 1'b0;
                  end
               end
               default: state_q <= StIdle;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_as5600_i2c_target.sv
// Bench for as5600_i2c_target: bit-banged I2C initiator plus a register-map
// model (pointer, ZPOS, snapshot) predicting every byte and ACK.
module tb_as5600_i2c_target;

   localparam int         Q    = 10;
   localparam logic [6:0] ADDR = 7'h36;
`ifdef AS5600_TGT_WRITE_EN
   localparam bit WE = 1'b1;
`else
   localparam bit WE = 1'b0;
`endif

   logic        clk     = 1'b0;
   logic        rstn    = 1'b0;
   logic        scl     = 1'b1;
   logic        sda_drv = 1'b0;
   logic [11:0] phi     = '0;
   logic        busy, snap;
   wire         sda_line;

   int          n_vec    = 0;
   int          n_err    = 0;
   int          m_ptr    = 0;
   logic [11:0] m_zpos   = '0;
   int          snap_cnt = 0;
   int          busy_cnt = 0;

   pullup (sda_line);
   assign sda_line = sda_drv ? 1'b0 : 1'bz;

   as5600_i2c_target #(.I2C_ADDR(ADDR), .FILT_LEN(3)) dut (
      .clk    (clk),
      .rstn   (rstn),
      .scl    (scl),
      .sda    (sda_line),
      .i_phi  (phi),
      .o_busy (busy),
      .o_snap (snap)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (snap === 1'b1) snap_cnt++;
      if (busy === 1'b1) busy_cnt++;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] exp_reg(input int p, input logic [11:0] s);
      logic [11:0] ang;
      ang = s - m_zpos;
      if (WE && p == 1) return {4'h0, m_zpos[11:8]};
      if (WE && p == 2) return m_zpos[7:0];
      if (p == 8'h0B) return 8'h20;
      if (p == 8'h0C) return {4'h0, s[11:8]};
      if (p == 8'h0D) return s[7:0];
      if (p == 8'h0E) return {4'h0, ang[11:8]};
      if (p == 8'h0F) return ang[7:0];
      return 8'h00;
   endfunction

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic i2c_start();
      sda_drv = 1'b0; tick(Q);
      scl = 1'b1;     tick(Q);
      sda_drv = 1'b1; tick(Q);
      scl = 1'b0;     tick(Q);
   endtask

   task automatic i2c_stop();
      sda_drv = 1'b1; tick(Q);
      scl = 1'b1;     tick(Q);
      sda_drv = 1'b0; tick(Q);
   endtask

   task automatic bit_out(input logic b);
      sda_drv = ~b; tick(Q);
      scl = 1'b1;   tick(2 * Q);
      scl = 1'b0;   tick(Q);
   endtask

   task automatic bit_in(output logic b);
      sda_drv = 1'b0; tick(Q);
      scl = 1'b1;     tick(Q);
      b = sda_line;   tick(Q);
      scl = 1'b0;     tick(Q);
   endtask

   task automatic write_byte(input logic [7:0] d, output logic ack);
      logic b;
      for (int i = 7; i >= 0; i--) bit_out(d[i]);
      bit_in(b);
      ack = (b === 1'b0);
   endtask

   task automatic read_byte(output logic [7:0] d, input logic ack);
      logic b;
      for (int i = 7; i >= 0; i--) begin
         bit_in(b);
         d[i] = b;
      end
      bit_out(~ack);
   endtask

   task automatic set_ptr(input logic [7:0] p, input logic with_stop);
      logic ack;
      i2c_start();
      write_byte({ADDR, 1'b0}, ack);
      check_eq("wr_addr_ack", ack, 1);
      write_byte(p, ack);
      check_eq("ptr_ack", ack, 1);
      m_ptr = p;
      if (with_stop) i2c_stop();
   endtask

   // Snapshot is p0; i_phi moves to pmid after the first byte and randomly after
   task automatic do_read(input int n, input logic [11:0] p0, input logic [11:0] pmid);
      logic       ack;
      logic [7:0] d;
      int         s0;
      phi = p0;
      s0  = snap_cnt;
      i2c_start();
      write_byte({ADDR, 1'b1}, ack);
      check_eq("rd_addr_ack", ack, 1);
      for (int i = 0; i < n; i++) begin
         read_byte(d, i != n - 1);
         check_eq($sformatf("rd_byte@%02h", m_ptr), d, exp_reg(m_ptr, p0));
         m_ptr = (m_ptr + 1) % 256;
         phi = (i == 0) ? pmid : 12'($urandom);
      end
      i2c_stop();
      check_eq("snap_pulses", snap_cnt - s0, 1);
   endtask

   task automatic do_write(input logic [7:0] p, input logic [15:0] data, input int n);
      logic       ack;
      logic [7:0] d;
      set_ptr(p, 1'b0);
      for (int i = 0; i < n; i++) begin
         d = (i == 0) ? data[15:8] : data[7:0];
         write_byte(d, ack);
         check_eq("wr_data_ack", ack, WE);
         if (!WE) break;
         if (m_ptr == 1) m_zpos[11:8] = d[3:0];
         else if (m_ptr == 2) m_zpos[7:0] = d;
         m_ptr = (m_ptr + 1) % 256;
      end
      i2c_stop();
   endtask

   logic [7:0] pick [8] = '{8'h00, 8'h01, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'hFE};

   initial begin
      logic       ack, b, rel;
      logic [3:0] first4;
      int         b0;
      logic [6:0] wa;

      // Reset state
      tick(3);
      check_eq("rst_sda", sda_line, 1);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_snap", snap, 0);
      rstn = 1'b1;
      tick(10);

      // Pointer write, repeated START, coherent 2-byte raw read
      b0 = busy_cnt;
      set_ptr(8'h0C, 1'b0);
      do_read(2, 12'hABC, 12'hABC);
      check_eq("busy_seen", busy_cnt > b0, 1);

      // Wrong address: no ACK, never busy
      b0 = busy_cnt;
      i2c_start();
      write_byte({7'h37, 1'b0}, ack);
      check_eq("bad_addr_nack", ack, 0);
      i2c_stop();
      check_eq("bad_addr_busy", busy_cnt - b0, 0);

      // Pointer wrap FE,FF,00,01 then current-address read up to STATUS
      set_ptr(8'hFE, 1'b1);
      do_read(4, 12'($urandom), 12'($urandom));
      do_read(10, 12'($urandom), 12'($urandom));

      // i_phi changes between hi and lo byte
      set_ptr(8'h0C, 1'b1);
      do_read(2, 12'h100, 12'hFFF);

      // ZPOS write (or NACK without the write feature), angle readback
      do_write(8'h01, 16'h0010, 2);
      set_ptr(8'h0E, 1'b1);
      do_read(2, 12'h005, 12'($urandom));
      set_ptr(8'h01, 1'b1);
      do_read(2, 12'($urandom), 12'($urandom));

      // Randomized transactions
      for (int it = 0; it < 12; it++) begin
         if ($urandom_range(0, 3) == 0) begin
            wa = ADDR ^ 7'(1 << $urandom_range(0, 6));
            b0 = busy_cnt;
            i2c_start();
            write_byte({wa, 1'($urandom_range(0, 1))}, ack);
            check_eq("rnd_bad_addr", ack, 0);
            i2c_stop();
            check_eq("rnd_bad_busy", busy_cnt - b0, 0);
         end else begin
            set_ptr(pick[$urandom_range(0, 7)], 1'($urandom_range(0, 1)));
            do_read($urandom_range(1, 3), 12'($urandom), 12'($urandom));
         end
      end

      // Reset while the target drives a 0 in the 5th bit of 0xA5
      set_ptr(8'h0D, 1'b1);
      phi = 12'h0A5;
      i2c_start();
      write_byte({ADDR, 1'b1}, ack);
      check_eq("rr_addr_ack", ack, 1);
      for (int i = 3; i >= 0; i--) begin
         bit_in(b);
         first4[i] = b;
      end
      check_eq("rr_first_bits", first4, 4'hA);
      sda_drv = 1'b0; tick(Q);
      scl = 1'b1;     tick(Q / 2);
      rstn = 1'b0;    tick(2);
      check_eq("mid_rst_sda", sda_line, 1);
      check_eq("mid_rst_busy", busy, 0);
      rstn = 1'b1;
      m_ptr = 0;
      m_zpos = '0;
      b0 = busy_cnt;
      tick(Q / 2);
      scl = 1'b0; tick(Q);
      rel = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bit_in(b);
         rel &= b;
      end
      bit_out(1'b1);
      check_eq("post_rst_released", rel, 1);

      // One-clock SDA glitches with SCL high: low pulse, then high pulse
      scl = 1'b1;     tick(Q);
      sda_drv = 1'b1; tick(1);
      sda_drv = 1'b0; tick(Q);
      scl = 1'b0;     tick(Q);
      sda_drv = 1'b1; tick(Q);
      scl = 1'b1;     tick(Q);
      sda_drv = 1'b0; tick(1);
      sda_drv = 1'b1; tick(Q);
      scl = 1'b0;     tick(Q);
      write_byte({ADDR, 1'b0}, ack);
      check_eq("glitch_no_start", ack, 0);
      i2c_stop();
      check_eq("glitch_busy", busy_cnt - b0, 0);

      // Target works again after a fresh START
      set_ptr(8'h0B, 1'b1);
      do_read(1, 12'($urandom), 12'($urandom));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
